// File: rtl/csr_unit_if.sv
// CSR access, exception/ertn commit, interrupt and redirect signals between the pipeline (master) and csr_unit (slave).
// Pure wiring: no latency, no backpressure.
interface csr_unit_if;
  logic        csr_re;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        wb_ex;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic        ertn_flush;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic [31:0] coreid_in;
  logic        has_int;
  logic [31:0] ex_entry;
  logic [31:0] ertn_entry;

  modport master (
    output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
           wb_ex, wb_pc, wb_vaddr, wb_ecode, wb_esubcode, ertn_flush,
           hw_int_in, ipi_int_in, coreid_in,
    input  csr_rvalue, has_int, ex_entry, ertn_entry
  );

  modport slave (
    input  csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
           wb_ex, wb_pc, wb_vaddr, wb_ecode, wb_esubcode, ertn_flush,
           hw_int_in, ipi_int_in, coreid_in,
    output csr_rvalue, has_int, ex_entry, ertn_entry
  );
endinterface

// File: rtl/csr_unit.sv
// Control/status register file with exception/ertn state, interrupt pending and optional timer (CSR_TIMER_EN).
// Reads are combinational from csr_num; writes and commit effects land on the next posedge.
// No backpressure: every request is accepted in its cycle.
module csr_unit (
  input  logic       clk,
  input  logic       resetn,
  csr_unit_if.slave  csr
);
  localparam logic [13:0] CRMD   = 14'h00;
  localparam logic [13:0] PRMD   = 14'h01;
  localparam logic [13:0] ECFG   = 14'h04;
  localparam logic [13:0] ESTAT  = 14'h05;
  localparam logic [13:0] ERA    = 14'h06;
  localparam logic [13:0] BADV   = 14'h07;
  localparam logic [13:0] EENTRY = 14'h0C;
  localparam logic [13:0] SAVE0  = 14'h30;
  localparam logic [13:0] SAVE1  = 14'h31;
  localparam logic [13:0] SAVE2  = 14'h32;
  localparam logic [13:0] SAVE3  = 14'h33;
  localparam logic [13:0] TID    = 14'h40;
  localparam logic [13:0] TCFG   = 14'h41;
  localparam logic [13:0] TVAL   = 14'h42;
  localparam logic [13:0] TICLR  = 14'h44;

  logic [8:0]       crmd_q, crmd_d;
  logic [2:0]       prmd_q, prmd_d;
  logic [12:0]      ecfg_q, ecfg_d;
  logic [1:0]       is_sw_q, is_sw_d;
  logic [7:0]       is_hw_q;
  logic             is_ipi_q;
  logic             is_ti;
  logic [5:0]       ecode_q, ecode_d;
  logic [8:0]       esub_q, esub_d;
  logic [31:0]      era_q, era_d;
  logic [31:0]      badv_q, badv_d;
  logic [25:0]      eentry_q, eentry_d;
  logic [3:0][31:0] save_q, save_d;
  logic [31:0]      rdata;
  logic [31:0]      wdat;
  logic             wr_en;

  // Commit pulses own the cycle; a coincident software write is dropped.
  assign wr_en = csr.csr_we & ~csr.wb_ex & ~csr.ertn_flush;
  // Merging against the current read value leaves unmasked bits as they were.
  assign wdat  = (csr.csr_wmask & csr.csr_wvalue) | (~csr.csr_wmask & rdata);

`ifdef CSR_TIMER_EN
  logic [31:0] tid_q, tid_d;
  logic [31:0] tcfg_q, tcfg_d;
  logic [31:0] tval_q, tval_d;
  logic        ti_q, ti_d;
  logic        unused_csr_re;

  assign unused_csr_re = csr.csr_re;
  assign is_ti = ti_q;

  always_comb begin
    tid_d  = tid_q;
    tcfg_d = tcfg_q;
    tval_d = tval_q;
    ti_d   = ti_q;
    if (wr_en && csr.csr_num == TICLR && wdat[0]) ti_d = 1'b0;
    if (wr_en && csr.csr_num == TID) tid_d = wdat;
    if (wr_en && csr.csr_num == TCFG) begin
      tcfg_d = wdat;
      tval_d = {wdat[31:2], 2'b00};
    end else if (tcfg_q[0]) begin
      if (tval_q != 32'd0) begin
        tval_d = tval_q - 32'd1;
        if (tval_q == 32'd1) ti_d = 1'b1;  // set overrides a same-cycle TICLR
      end else if (tcfg_q[1]) begin
        tval_d = {tcfg_q[31:2], 2'b00};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tid_q  <= csr.coreid_in;
      tcfg_q <= '0;
      tval_q <= '0;
      ti_q   <= 1'b0;
    end else begin
      tid_q  <= tid_d;
      tcfg_q <= tcfg_d;
      tval_q <= tval_d;
      ti_q   <= ti_d;
    end
  end
`else
  logic unused_inputs;

  assign unused_inputs = csr.csr_re ^ (^csr.coreid_in);
  assign is_ti = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    case (csr.csr_num)
      CRMD:   rdata = {23'b0, crmd_q};
      PRMD:   rdata = {29'b0, prmd_q};
      ECFG:   rdata = {19'b0, ecfg_q};
      ESTAT:  rdata = {1'b0, esub_q, ecode_q, 3'b0, is_ipi_q, is_ti, 1'b0, is_hw_q, is_sw_q};
      ERA:    rdata = era_q;
      BADV:   rdata = badv_q;
      EENTRY: rdata = {eentry_q, 6'b0};
      SAVE0:  rdata = save_q[0];
      SAVE1:  rdata = save_q[1];
      SAVE2:  rdata = save_q[2];
      SAVE3:  rdata = save_q[3];
`ifdef CSR_TIMER_EN
      TID:    rdata = tid_q;
      TCFG:   rdata = tcfg_q;
      TVAL:   rdata = tval_q;
`endif
      default: rdata = '0;
    endcase
  end

  always_comb begin
    crmd_d   = crmd_q;
    prmd_d   = prmd_q;
    ecfg_d   = ecfg_q;
    is_sw_d  = is_sw_q;
    ecode_d  = ecode_q;
    esub_d   = esub_q;
    era_d    = era_q;
    badv_d   = badv_q;
    eentry_d = eentry_q;
    save_d   = save_q;
    if (csr.wb_ex) begin
      prmd_d      = crmd_q[2:0];
      crmd_d[2:0] = 3'b000;
      era_d       = csr.wb_pc;
      ecode_d     = csr.wb_ecode;
      esub_d      = csr.wb_esubcode;
      if (csr.wb_ecode == 6'h08)      badv_d = csr.wb_pc;
      else if (csr.wb_ecode == 6'h09) badv_d = csr.wb_vaddr;
    end else if (csr.ertn_flush) begin
      crmd_d[2:0] = prmd_q;
    end else if (csr.csr_we) begin
      case (csr.csr_num)
        CRMD:    crmd_d    = wdat[8:0];
        PRMD:    prmd_d    = wdat[2:0];
        ECFG:    ecfg_d    = wdat[12:0] & 13'h1BFF;
        ESTAT:   is_sw_d   = wdat[1:0];
        ERA:     era_d     = wdat;
        BADV:    badv_d    = wdat;
        EENTRY:  eentry_d  = wdat[31:6];
        SAVE0:   save_d[0] = wdat;
        SAVE1:   save_d[1] = wdat;
        SAVE2:   save_d[2] = wdat;
        SAVE3:   save_d[3] = wdat;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      crmd_q   <= 9'h008;
      prmd_q   <= '0;
      ecfg_q   <= '0;
      is_sw_q  <= '0;
      is_hw_q  <= '0;
      is_ipi_q <= 1'b0;
      ecode_q  <= '0;
      esub_q   <= '0;
      era_q    <= '0;
      badv_q   <= '0;
      eentry_q <= '0;
      save_q   <= '0;
    end else begin
      crmd_q   <= crmd_d;
      prmd_q   <= prmd_d;
      ecfg_q   <= ecfg_d;
      is_sw_q  <= is_sw_d;
      is_hw_q  <= csr.hw_int_in;
      is_ipi_q <= csr.ipi_int_in;
      ecode_q  <= ecode_d;
      esub_q   <= esub_d;
      era_q    <= era_d;
      badv_q   <= badv_d;
      eentry_q <= eentry_d;
      save_q   <= save_d;
    end
  end

  assign csr.csr_rvalue = rdata;
  assign csr.has_int    = crmd_q[2] & |({is_ipi_q, is_ti, 1'b0, is_hw_q, is_sw_q} & ecfg_q);
  assign csr.ex_entry   = {eentry_q, 6'b0};
  assign csr.ertn_entry = era_q;
endmodule

// File: tb/tb_csr_unit.sv
// Directed-vector bench for csr_unit; timer scenarios follow the CSR_TIMER_EN build option.
module tb_csr_unit;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [31:0] v;

  csr_unit_if bus ();

  csr_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .csr    (bus.slave)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [13:0] n, output logic [31:0] val);
    bus.csr_num = n;
    #1;
    val = bus.csr_rvalue;
  endtask

  task automatic wr(input logic [13:0] n, input logic [31:0] m, input logic [31:0] d);
    bus.csr_we     = 1'b1;
    bus.csr_num    = n;
    bus.csr_wmask  = m;
    bus.csr_wvalue = d;
    tick();
    bus.csr_we     = 1'b0;
  endtask

  task automatic do_reset();
    bus.csr_re = 1'b0;      bus.csr_num = '0;        bus.csr_we = 1'b0;
    bus.csr_wmask = '0;     bus.csr_wvalue = '0;     bus.wb_ex = 1'b0;
    bus.wb_pc = '0;         bus.wb_vaddr = '0;       bus.wb_ecode = '0;
    bus.wb_esubcode = '0;   bus.ertn_flush = 1'b0;   bus.hw_int_in = '0;
    bus.ipi_int_in = 1'b0;  bus.coreid_in = 32'h0000_005A;
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic pulse_ex(input logic [5:0] ec, input logic [8:0] sub, input logic [31:0] pc, input logic [31:0] va);
    bus.wb_ex = 1'b1; bus.wb_ecode = ec; bus.wb_esubcode = sub; bus.wb_pc = pc; bus.wb_vaddr = va;
    tick();
    bus.wb_ex = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    wr(14'h30, 32'hFFFF_FFFF, 32'hAAAA_5555);
    // Reset coincident with an exception and a write must win.
    resetn = 1'b0;
    bus.wb_ex = 1'b1; bus.wb_pc = 32'h0000_1000; bus.wb_ecode = 6'h08;
    bus.csr_we = 1'b1; bus.csr_num = 14'h30; bus.csr_wmask = '1; bus.csr_wvalue = 32'h1234_5678;
    tick();
    bus.wb_ex = 1'b0; bus.csr_we = 1'b0; resetn = 1'b1;
    rd(14'h00, v); n_checks++;
    if (v !== 32'h0000_0008) begin n_fail++; $display("FAIL reset_crmd got %h exp %h", v, 32'h8); end
    rd(14'h41, v); n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL reset_tcfg got %h exp 0", v); end
    rd(14'h30, v); n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL reset_save0 got %h exp 0", v); end
    rd(14'h06, v); n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL reset_era got %h exp 0", v); end
    rd(14'h05, v); n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL reset_estat got %h exp 0", v); end
    n_checks++;
    if ({bus.has_int, bus.ex_entry, bus.ertn_entry} !== 65'd0) begin
      n_fail++; $display("FAIL reset_outputs got %b/%h/%h exp 0/0/0", bus.has_int, bus.ex_entry, bus.ertn_entry);
    end
    rd(14'h40, v); n_checks++;
`ifdef CSR_TIMER_EN
    if (v !== 32'h0000_005A) begin n_fail++; $display("FAIL reset_tid got %h exp 5a", v); end
`else
    if (v !== 32'h0) begin n_fail++; $display("FAIL reset_tid got %h exp 0", v); end
`endif
  endtask

  task automatic test_exception();
    do_reset();
    wr(14'h00, 32'h7, 32'h7);
    pulse_ex(6'h09, 9'h0, 32'h1C00_0100, 32'h0000_0003);
    rd(14'h06, v); n_checks++;
    if (v !== 32'h1C00_0100) begin n_fail++; $display("FAIL ex_era got %h exp 1c000100", v); end
    rd(14'h07, v); n_checks++;
    if (v !== 32'h3) begin n_fail++; $display("FAIL ex_badv got %h exp 3", v); end
    rd(14'h00, v); n_checks++;
    if (v !== 32'h8) begin n_fail++; $display("FAIL ex_crmd got %h exp 8", v); end
    rd(14'h01, v); n_checks++;
    if (v !== 32'h7) begin n_fail++; $display("FAIL ex_prmd got %h exp 7", v); end
    rd(14'h05, v); n_checks++;
    if (v !== 32'h0009_0000) begin n_fail++; $display("FAIL ex_estat got %h exp 00090000", v); end
    n_checks++;
    if (bus.ertn_entry !== 32'h1C00_0100) begin n_fail++; $display("FAIL ex_ertn_entry got %h exp 1c000100", bus.ertn_entry); end
    bus.ertn_flush = 1'b1;
    tick();
    bus.ertn_flush = 1'b0;
    rd(14'h00, v); n_checks++;
    if (v !== 32'hF) begin n_fail++; $display("FAIL ertn_crmd got %h exp f", v); end
  endtask

  task automatic test_badv();
    do_reset();
    pulse_ex(6'h08, 9'h1, 32'h1C00_0200, 32'h0000_0055);
    rd(14'h07, v); n_checks++;
    if (v !== 32'h1C00_0200) begin n_fail++; $display("FAIL badv_ecode8 got %h exp 1c000200", v); end
    rd(14'h05, v); n_checks++;
    if (v !== 32'h0048_0000) begin n_fail++; $display("FAIL estat_subcode got %h exp 00480000", v); end
    pulse_ex(6'h03, 9'h0, 32'h1C00_0300, 32'h0000_0066);
    rd(14'h07, v); n_checks++;
    if (v !== 32'h1C00_0200) begin n_fail++; $display("FAIL badv_other got %h exp 1c000200", v); end
    rd(14'h06, v); n_checks++;
    if (v !== 32'h1C00_0300) begin n_fail++; $display("FAIL era_second got %h exp 1c000300", v); end
  endtask

  task automatic test_conflict();
    do_reset();
    bus.wb_ex = 1'b1; bus.wb_ecode = 6'h03; bus.wb_pc = 32'h40;
    wr(14'h30, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
    bus.wb_ex = 1'b0;
    rd(14'h30, v); n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL conflict_wbex got %h exp 0", v); end
    bus.ertn_flush = 1'b1;
    wr(14'h31, 32'hFFFF_FFFF, 32'hCAFE_F00D);
    bus.ertn_flush = 1'b0;
    rd(14'h31, v); n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL conflict_ertn got %h exp 0", v); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.csr_we = 1'b1; bus.csr_num = 14'h32; bus.csr_wmask = '1; bus.csr_wvalue = 32'h1234_5678;
    #1; v = bus.csr_rvalue; n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL raw_old got %h exp 0", v); end
    tick();
    bus.csr_wvalue = 32'h8765_4321;
    #1; v = bus.csr_rvalue; n_checks++;
    if (v !== 32'h1234_5678) begin n_fail++; $display("FAIL raw_new got %h exp 12345678", v); end
    tick();
    bus.csr_we = 1'b0;
    rd(14'h32, v); n_checks++;
    if (v !== 32'h8765_4321) begin n_fail++; $display("FAIL b2b_second got %h exp 87654321", v); end
    wr(14'h00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd(14'h00, v); n_checks++;
    if (v !== 32'h1FF) begin n_fail++; $display("FAIL crmd_mask got %h exp 1ff", v); end
    wr(14'h02, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd(14'h02, v); n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL unmapped got %h exp 0", v); end
  endtask

  task automatic test_masked_write();
    do_reset();
    wr(14'h0C, 32'hFFFF_FFFF, 32'h0000_00FF);
    rd(14'h0C, v); n_checks++;
    if (v !== 32'h0000_00C0) begin n_fail++; $display("FAIL eentry_low got %h exp c0", v); end
    wr(14'h0C, 32'hFFFF_FF00, 32'h1C00_8FFF);
    rd(14'h0C, v); n_checks++;
    if (v !== 32'h1C00_8FC0) begin n_fail++; $display("FAIL eentry_masked got %h exp 1c008fc0", v); end
    n_checks++;
    if (bus.ex_entry !== 32'h1C00_8FC0) begin n_fail++; $display("FAIL ex_entry got %h exp 1c008fc0", bus.ex_entry); end
  endtask

  task automatic test_interrupts();
    do_reset();
    wr(14'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd(14'h04, v); n_checks++;
    if (v !== 32'h1BFF) begin n_fail++; $display("FAIL ecfg_mask got %h exp 1bff", v); end
    wr(14'h05, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd(14'h05, v); n_checks++;
    if (v !== 32'h3) begin n_fail++; $display("FAIL estat_sw got %h exp 3", v); end
    n_checks++;
    if (bus.has_int !== 1'b0) begin n_fail++; $display("FAIL int_ie_off got %b exp 0", bus.has_int); end
    wr(14'h00, 32'h4, 32'h4);
    n_checks++;
    if (bus.has_int !== 1'b1) begin n_fail++; $display("FAIL int_sw got %b exp 1", bus.has_int); end
    wr(14'h05, 32'h3, 32'h0);
    wr(14'h04, 32'hFFFF_FFFF, 32'h4);
    n_checks++;
    if (bus.has_int !== 1'b0) begin n_fail++; $display("FAIL int_sw_clear got %b exp 0", bus.has_int); end
    bus.hw_int_in = 8'h01;
    #1; n_checks++;
    if (bus.has_int !== 1'b0) begin n_fail++; $display("FAIL int_hw_early got %b exp 0", bus.has_int); end
    tick();
    n_checks++;
    if (bus.has_int !== 1'b1) begin n_fail++; $display("FAIL int_hw got %b exp 1", bus.has_int); end
    rd(14'h05, v); n_checks++;
    if (v !== 32'h4) begin n_fail++; $display("FAIL estat_hw got %h exp 4", v); end
    bus.hw_int_in = 8'h00; bus.ipi_int_in = 1'b1;
    wr(14'h04, 32'hFFFF_FFFF, 32'h1000);
    rd(14'h05, v); n_checks++;
    if (v !== 32'h1000) begin n_fail++; $display("FAIL estat_ipi got %h exp 1000", v); end
    n_checks++;
    if (bus.has_int !== 1'b1) begin n_fail++; $display("FAIL int_ipi got %b exp 1", bus.has_int); end
    wr(14'h00, 32'h4, 32'h0);
    n_checks++;
    if (bus.has_int !== 1'b0) begin n_fail++; $display("FAIL int_ie_clear got %b exp 0", bus.has_int); end
  endtask

`ifdef CSR_TIMER_EN
  task automatic test_timer_oneshot();
    do_reset();
    wr(14'h04, 32'h800, 32'h800);
    wr(14'h00, 32'h4, 32'h4);
    wr(14'h41, 32'hFFFF_FFFF, 32'h9);
    rd(14'h42, v); n_checks++;
    if (v !== 32'h8) begin n_fail++; $display("FAIL tval_load got %h exp 8", v); end
    repeat (7) tick();
    rd(14'h42, v); n_checks++;
    if (v !== 32'h1 || bus.has_int !== 1'b0) begin n_fail++; $display("FAIL tval_one got %h/%b exp 1/0", v, bus.has_int); end
    tick();
    rd(14'h05, v); n_checks++;
    if (v[11] !== 1'b1 || bus.has_int !== 1'b1) begin n_fail++; $display("FAIL timer_fire got %b/%b exp 1/1", v[11], bus.has_int); end
    repeat (3) tick();
    rd(14'h42, v); n_checks++;
    if (v !== 32'h0 || bus.has_int !== 1'b1) begin n_fail++; $display("FAIL oneshot_hold got %h/%b exp 0/1", v, bus.has_int); end
    wr(14'h44, 32'h1, 32'h1);
    n_checks++;
    if (bus.has_int !== 1'b0) begin n_fail++; $display("FAIL ticlr got %b exp 0", bus.has_int); end
    rd(14'h44, v); n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL ticlr_read got %h exp 0", v); end
    repeat (5) tick();
    rd(14'h05, v); n_checks++;
    if (v[11] !== 1'b0) begin n_fail++; $display("FAIL oneshot_no_refire got %b exp 0", v[11]); end
  endtask

  task automatic test_timer_periodic();
    do_reset();
    wr(14'h41, 32'hFFFF_FFFF, 32'hB);
    repeat (8) tick();
    rd(14'h05, v); n_checks++;
    if (v[11] !== 1'b1) begin n_fail++; $display("FAIL periodic_first got %b exp 1", v[11]); end
    wr(14'h44, 32'h1, 32'h1);
    rd(14'h42, v); n_checks++;
    if (v !== 32'h8) begin n_fail++; $display("FAIL periodic_reload got %h exp 8", v); end
    rd(14'h05, v); n_checks++;
    if (v[11] !== 1'b0) begin n_fail++; $display("FAIL periodic_clear got %b exp 0", v[11]); end
    repeat (7) tick();
    rd(14'h05, v); n_checks++;
    if (v[11] !== 1'b0) begin n_fail++; $display("FAIL periodic_early got %b exp 0", v[11]); end
    wr(14'h44, 32'h1, 32'h1);
    rd(14'h05, v); n_checks++;
    if (v[11] !== 1'b1) begin n_fail++; $display("FAIL set_wins got %b exp 1", v[11]); end
  endtask
`else
  task automatic test_timer_absent();
    do_reset();
    wr(14'h41, 32'hFFFF_FFFF, 32'hB);
    wr(14'h40, 32'hFFFF_FFFF, 32'h1234);
    repeat (12) tick();
    rd(14'h41, v); n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL notimer_tcfg got %h exp 0", v); end
    rd(14'h40, v); n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL notimer_tid got %h exp 0", v); end
    rd(14'h42, v); n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL notimer_tval got %h exp 0", v); end
    rd(14'h05, v); n_checks++;
    if (v[11] !== 1'b0) begin n_fail++; $display("FAIL notimer_is11 got %b exp 0", v[11]); end
  endtask
`endif

  initial begin
    test_reset();
    test_exception();
    test_badv();
    test_conflict();
    test_back_to_back();
    test_masked_write();
    test_interrupts();
`ifdef CSR_TIMER_EN
    test_timer_oneshot();
    test_timer_periodic();
`else
    test_timer_absent();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
